// File: rtl/tomasulo_pkg.sv
// Shared definitions for the tomasulo core: opcodes, widths and the
// reorder-buffer entry bookkeeping record.
package tomasulo_pkg;

  localparam int DATA_W    = 16;
  localparam int ROB_DEPTH = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNEQ = 4'b0111;

  // Control part of an entry; the result word lives in a separate array so
  // its width can follow the DATA_W parameter of each instance.
  typedef struct packed {
    logic       busy;
    logic       ready;
    logic [3:0] func;
    logic [3:0] rd;
  } rob_entry_t;

  function automatic logic is_branch(input logic [3:0] func);
    return (func == OP_BEQ) || (func == OP_BNEQ);
  endfunction

endpackage

// File: rtl/rob_tag_lookup.sv
// Combinational operand read port into the reorder buffer, with a bypass
// from the writeback bus arriving in the same cycle.
module rob_tag_lookup #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic [IDX_W-1:0]             tag,
  input  logic [DEPTH-1:0]             entry_ready,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic                         wb_valid,
  input  logic [IDX_W-1:0]             wb_idx,
  input  logic [DATA_W-1:0]            wb_data,
  output logic                         ready,
  output logic [DATA_W-1:0]            data
);

  always_comb begin
    ready = entry_ready[tag];
    data  = entry_data[tag];
    if (wb_valid && (wb_idx == tag)) begin
      ready = 1'b1;
      data  = wb_data;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags issued instructions, captures results,
// serves operand lookups and retires in order with taken-branch flush.
module reorder_buffer #(
  parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [3:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [IDX_W-1:0]  rd_tag_a,
  input  logic [IDX_W-1:0]  rd_tag_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              commit_valid,
  output logic [3:0]        commit_func,
  output logic [3:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [IDX_W-1:0]  commit_idx,
  output logic              flush,
  output logic [3:0]        flush_pc,
  output logic [IDX_W:0]    count
);
  import tomasulo_pkg::rob_entry_t;
  import tomasulo_pkg::is_branch;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  rob_entry_t                   ent [DEPTH];
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             ent_ready;
  logic [IDX_W-1:0]             head, tail;
  rob_entry_t                   head_ent;
  logic                         commit_take, flush_take, alloc_fire, wb_fire;

  // Handshake: an allocation transfers on a cycle where alloc_valid and
  // alloc_ready are both high; alloc_ready never depends on alloc_valid.
  // Writeback, commit and flush are valid-only pulses with no backpressure.
  assign head_ent    = ent[head];
  assign commit_take = head_ent.busy && head_ent.ready;
  assign flush_take  = commit_take && is_branch(head_ent.func) && ent_data[head][0];
  // No commit-to-alloc bypass when full; a flushing cycle accepts nothing.
  assign alloc_ready = (count < FULL_CNT) && !flush_take;
  assign alloc_idx   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_fire     = wb_valid && ent[wb_idx].busy;

  always_comb begin
    ent_ready = '0;
    for (int i = 0; i < DEPTH; i++) ent_ready[i] = ent[i].ready;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]      <= '0;
        ent_data[i] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_func  <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      commit_idx   <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= commit_take;
      flush        <= flush_take;
      if (commit_take) begin
        commit_func <= head_ent.func;
        commit_rd   <= head_ent.rd;
        commit_data <= ent_data[head];
        commit_idx  <= head;
      end
      if (flush_take) begin
        flush_pc <= head_ent.rd;
        for (int i = 0; i < DEPTH; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wb_fire) begin
          ent[wb_idx].ready <= 1'b1;
          ent_data[wb_idx]  <= wb_data;
        end
        // The tail entry is never busy while alloc_ready is high, so it
        // cannot collide with the writeback above.
        if (alloc_fire) begin
          ent[tail].busy  <= 1'b1;
          ent[tail].ready <= 1'b0;
          ent[tail].func  <= alloc_func;
          ent[tail].rd    <= alloc_rd;
          tail            <= tail + 1'b1;
        end
        if (commit_take) begin
          ent[head].busy <= 1'b0;
          head           <= head + 1'b1;
        end
        case ({alloc_fire, commit_take})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  rob_tag_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_lookup_a (
    .tag         (rd_tag_a),
    .entry_ready (ent_ready),
    .entry_data  (ent_data),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .ready       (rd_ready_a),
    .data        (rd_data_a)
  );

  rob_tag_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_lookup_b (
    .tag         (rd_tag_b),
    .entry_ready (ent_ready),
    .entry_data  (ent_data),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .ready       (rd_ready_b),
    .data        (rd_data_b)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order writeback,
// in-order retire with wrap, stores, branch flush, bypass and async reset.
module tb_reorder_buffer;
  import tomasulo_pkg::*;

  localparam int IW = 3;
  localparam int REC_W = IW + 4 + 4 + 16;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [3:0]    alloc_func;
  logic [3:0]    alloc_rd;
  logic          alloc_ready;
  logic [IW-1:0] alloc_idx;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [15:0]   wb_data;
  logic [IW-1:0] rd_tag_a, rd_tag_b;
  logic          rd_ready_a, rd_ready_b;
  logic [15:0]   rd_data_a, rd_data_b;
  logic          commit_valid;
  logic [3:0]    commit_func;
  logic [3:0]    commit_rd;
  logic [15:0]   commit_data;
  logic [IW-1:0] commit_idx;
  logic          flush;
  logic [3:0]    flush_pc;
  logic [IW:0]   count;

  int checks = 0;
  int errors = 0;
  int flush_cnt = 0;
  logic [REC_W-1:0] obs_q[$];
  logic [REC_W-1:0] exp_q[$];

  reorder_buffer dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .commit_valid(commit_valid), .commit_func(commit_func), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_idx(commit_idx),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  // clock / reset
  always #5 clk1 = ~clk1;

  // commit monitor: records every retire pulse away from the active edge
  always @(negedge clk1) begin
    if (commit_valid) obs_q.push_back({commit_idx, commit_func, commit_rd, commit_data});
    if (flush) flush_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    wb_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_alloc(input logic [3:0] f, input logic [3:0] rd);
    alloc_valid = 1'b1;
    alloc_func = f;
    alloc_rd = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [IW-1:0] idx, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_idx = idx;
    wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic compare_commits(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_n: got %0d commits expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    rd_tag_a = '0; rd_tag_b = '0;
    rst = 1'b1;
    tick();
    checks++;
    if ({count, alloc_idx, alloc_ready} !== {4'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d idx=%0d rdy=%b expected 0 0 1", count, alloc_idx, alloc_ready);
    end
    checks++;
    if ({commit_valid, flush, flush_pc, rd_ready_a} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cv=%b fl=%b pc=%h ra=%b expected zeros", commit_valid, flush, flush_pc, rd_ready_a);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'd3;
    checks++;
    if (alloc_idx !== 3'd0) begin
      errors++; $display("FAIL basic_tag: got %0d expected 0", alloc_idx);
    end
    tick();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 4'd1) begin
      errors++; $display("FAIL basic_count1: got %0d expected 1", count);
    end
    do_wb(3'd0, 16'h0042);
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_no_fwd: got %b expected 0", commit_valid);
    end
    tick();
    checks++;
    if ({commit_valid, commit_rd, commit_data, commit_idx, count} !== {1'b1, 4'd3, 16'h0042, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL basic_commit: got v=%b rd=%0d d=%h idx=%0d cnt=%0d expected 1 3 0042 0 0",
               commit_valid, commit_rd, commit_data, commit_idx, count);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: got %b expected 0", commit_valid);
    end
  endtask

  task automatic test_full_ooo();
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(OP_ADD, 4'(i));
    checks++;
    if ({count, alloc_ready} !== {4'd8, 1'b0}) begin
      errors++; $display("FAIL full_state: got cnt=%0d rdy=%b expected 8 0", count, alloc_ready);
    end
    do_alloc(OP_MUL, 4'hF);
    checks++;
    if (count !== 4'd8) begin
      errors++; $display("FAIL full_reject: got %0d expected 8", count);
    end
    do_wb(3'd5, 16'h0105);
    rd_tag_a = 3'd5; rd_tag_b = 3'd3;
    #1;
    checks++;
    if ({rd_ready_a, rd_data_a, rd_ready_b} !== {1'b1, 16'h0105, 1'b0}) begin
      errors++;
      $display("FAIL full_lookup: got ra=%b da=%h rb=%b expected 1 0105 0", rd_ready_a, rd_data_a, rd_ready_b);
    end
    do_wb(3'd2, 16'h0102);
    do_wb(3'd0, 16'h0100);
    alloc_valid = 1'b1; alloc_func = OP_SUB; alloc_rd = 4'hE;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL full_no_bypass: got %b expected 0", alloc_ready);
    end
    do_wb(3'd1, 16'h0101);
    alloc_valid = 1'b0;
    checks++;
    if (count !== 4'd7) begin
      errors++; $display("FAIL full_commit_only: got %0d expected 7", count);
    end
    for (int i = 0; i < 4; i++) tick();
    for (int t = 0; t < 3; t++) exp_q.push_back({3'(t), OP_ADD, 4'(t), 16'h0100 + 16'(t)});
    compare_commits("ooo_order");
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("FAIL ooo_wait: got %0d expected 5", count);
    end
  endtask

  task automatic test_wrap();
    logic [IW-1:0] tag;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tag = 3'(i % 8);
      checks++;
      if (alloc_idx !== tag) begin
        errors++; $display("FAIL wrap_tag[%0d]: got %0d expected %0d", i, alloc_idx, tag);
      end
      exp_q.push_back({tag, OP_SUB, 4'(i), 16'h0200 + 16'(i)});
      do_alloc(OP_SUB, 4'(i));
      checks++;
      if (count !== 4'd1) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d expected 1", i, count);
      end
      do_wb(tag, 16'h0200 + 16'(i));
    end
    for (int i = 0; i < 3; i++) tick();
    compare_commits("wrap_order");
  endtask

  task automatic test_store();
    do_reset();
    do_alloc(OP_ST, 4'd9);
    do_wb(3'd0, 16'hBEEF);
    tick();
    tick();
    exp_q.push_back({3'd0, OP_ST, 4'd9, 16'hBEEF});
    compare_commits("store");
  endtask

  task automatic test_branch();
    do_reset();
    do_alloc(OP_BEQ, 4'd5);
    do_wb(3'd0, 16'h0000);
    tick();
    tick();
    exp_q.push_back({3'd0, OP_BEQ, 4'd5, 16'h0000});
    compare_commits("br_not_taken");
    checks++;
    if (flush_cnt !== 0) begin
      errors++; $display("FAIL br_nt_flush: got %0d flushes expected 0", flush_cnt);
    end
    do_alloc(OP_ADD, 4'd1);
    do_alloc(OP_BEQ, 4'hA);
    do_alloc(OP_SUB, 4'd4);
    do_wb(3'd1, 16'h0007);
    do_wb(3'd2, 16'h0001);
    alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'd6;
    wb_valid = 1'b1; wb_idx = 3'd3; wb_data = 16'h0009;
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b0;
    checks++;
    if ({flush, flush_pc, commit_valid, commit_func} !== {1'b1, 4'hA, 1'b1, OP_BEQ}) begin
      errors++;
      $display("FAIL br_taken: got fl=%b pc=%h cv=%b fn=%h expected 1 a 1 6", flush, flush_pc, commit_valid, commit_func);
    end
    rd_tag_a = 3'd3;
    #1;
    checks++;
    if ({count, alloc_idx, rd_ready_a} !== {4'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL br_cleared: got cnt=%0d idx=%0d ra=%b expected 0 0 0", count, alloc_idx, rd_ready_a);
    end
    tick();
    tick();
    checks++;
    if ({flush, commit_valid, count} !== {1'b0, 1'b0, 4'd0} || flush_cnt !== 1) begin
      errors++;
      $display("FAIL br_after: got fl=%b cv=%b cnt=%0d nflush=%0d expected 0 0 0 1", flush, commit_valid, count, flush_cnt);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(OP_LD, 4'(i));
    rd_tag_a = 3'd2; rd_tag_b = 3'd2;
    #1;
    checks++;
    if (rd_ready_b !== 1'b0) begin
      errors++; $display("FAIL byp_pre: got %b expected 0", rd_ready_b);
    end
    wb_valid = 1'b1; wb_idx = 3'd2; wb_data = 16'h1234;
    #1;
    checks++;
    if ({rd_ready_a, rd_data_a} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL byp_same: got %b %h expected 1 1234", rd_ready_a, rd_data_a);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if ({rd_ready_a, rd_data_a} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL byp_stored: got %b %h expected 1 1234", rd_ready_a, rd_data_a);
    end
  endtask

  task automatic test_reset_midop();
    do_alloc(OP_DIV, 4'd7);
    checks++;
    if (count !== 4'd4) begin
      errors++; $display("FAIL rst_pre: got %0d expected 4", count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({count, alloc_idx, alloc_ready, commit_valid, rd_ready_a} !== {4'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: got cnt=%0d idx=%0d rdy=%b cv=%b ra=%b expected 0 0 1 0 0",
               count, alloc_idx, alloc_ready, commit_valid, rd_ready_a);
    end
    rst = 1'b0;
    #1;
    alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'd2;
    checks++;
    if (alloc_idx !== 3'd0) begin
      errors++; $display("FAIL rst_next_tag: got %0d expected 0", alloc_idx);
    end
    tick();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 4'd1) begin
      errors++; $display("FAIL rst_next_count: got %0d expected 1", count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_ooo();
    test_wrap();
    test_store();
    test_branch();
    test_bypass();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
